// File: rtl/ab_seq_gen.sv
// A/B stimulus sequencer for an A-then-B-then-AB recognizer: PA, PB, HOLD x N, GAP per burst.
// Optional Q checker enabled by `define AB_SEQ_GEN_CHECK_EN (err tied low otherwise).
module ab_seq_gen (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] hold_len,
    input  logic [3:0] rep,
    input  logic       q_in,
    output logic       A,
    output logic       B,
    output logic       busy,
    output logic       done,
    output logic       err
);
    typedef enum logic [2:0] {IDLE, PA, PB, HOLD, GAP} state_t;

    state_t     state_q, state_d;
    logic [3:0] hold_lat_q, hold_lat_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic       done_q, done_d;

    always_comb begin
        state_d     = state_q;
        hold_lat_d  = hold_lat_q;
        hold_cnt_d  = hold_cnt_q;
        burst_cnt_d = burst_cnt_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = PA;
                    hold_lat_d  = (hold_len == 4'd0) ? 4'd1 : hold_len;
                    burst_cnt_d = (rep == 4'd0) ? 4'd1 : rep;
                end
            end
            PA: state_d = PB;
            PB: begin
                state_d    = HOLD;
                hold_cnt_d = hold_lat_q;
            end
            HOLD: begin
                if (hold_cnt_q <= 4'd1) begin
                    state_d    = GAP;
                    hold_cnt_d = 4'd0;
                end else begin
                    hold_cnt_d = hold_cnt_q - 4'd1;
                end
            end
            GAP: begin
                if (burst_cnt_q > 4'd1) begin
                    state_d     = PA;
                    burst_cnt_d = burst_cnt_q - 4'd1;
                end else begin
                    state_d     = IDLE;
                    burst_cnt_d = 4'd0;
                    done_d      = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Cancel wins over every in-run transition, including the final GAP's done.
        if (abort && (state_q != IDLE)) begin
            state_d     = IDLE;
            hold_lat_d  = 4'd0;
            hold_cnt_d  = 4'd0;
            burst_cnt_d = 4'd0;
            done_d      = 1'b0;
        end
        a_d = (state_d == PA) || (state_d == HOLD);
        b_d = (state_d == PB) || (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            hold_lat_q  <= 4'd0;
            hold_cnt_q  <= 4'd0;
            burst_cnt_q <= 4'd0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_lat_q  <= hold_lat_d;
            hold_cnt_q  <= hold_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            done_q      <= done_d;
        end
    end

    assign A    = a_q;
    assign B    = b_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;

`ifdef AB_SEQ_GEN_CHECK_EN
    logic err_q, err_d;

    // A correct recognizer reports Q exactly while both stimuli are held high.
    always_comb begin
        err_d = err_q;
        if (busy && (q_in != (state_q == HOLD)))
            err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= err_d;
    end

    assign err = err_q;
`else
    logic unused_q_in;
    assign unused_q_in = q_in;
    assign err         = 1'b0;
`endif

endmodule

// File: doc/ab_seq_gen.md
AB_SEQ_GEN -- requirements
Module: ab_seq_gen

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port rst  in  1  asynchronous, active-low reset (low = reset asserted).
REQ-003 SHALL have port start  in  1  request a run; sampled only in IDLE.
REQ-004 SHALL have port abort  in  1  synchronous run cancel; priority over all other inputs except rst.
REQ-005 SHALL have port hold_len  in  4  AND-phase length in cycles; 0 treated as 1; latched on start.
REQ-006 SHALL have port rep  in  4  bursts per run; 0 treated as 1; latched on start.
REQ-007 SHALL have port q_in  in  1  Q returned by the A-then-B-then-AB recognizer under test.
REQ-008 SHALL have port A  out  1  registered stimulus A toward the recognizer.
REQ-009 SHALL have port B  out  1  registered stimulus B toward the recognizer.
REQ-010 SHALL have port busy  out  1  high whenever state != IDLE.
REQ-011 SHALL have port done  out  1  one-cycle pulse at normal run completion.
REQ-012 SHALL have port err  out  1  sticky mismatch flag (checker).

Function
REQ-013 SHALL implement states IDLE, PA, PB, HOLD, GAP with registered A/B per state: IDLE 0/0, PA 1/0, PB 0/1, HOLD 1/1, GAP 0/0.
REQ-014 SHALL move IDLE->PA on the edge sampling start=1; A=1 visible the following cycle; start in any other state ignored.
REQ-015 SHALL stay in PA and PB exactly one cycle each (PA->PB->HOLD).
REQ-016 SHALL stay in HOLD for max(hold_len,1) cycles using a 4-bit down-counter, then enter GAP.
REQ-017 SHALL stay in GAP one cycle; then PA if bursts remain, else IDLE.
REQ-018 SHALL count bursts with a 4-bit counter; run length = max(rep,1) * (max(hold_len,1)+3) cycles.
REQ-019 SHALL pulse done for exactly the first IDLE cycle after the final GAP; done never asserts after abort.
REQ-020 SHALL accept start in the same cycle done is high (back-to-back runs, no dead cycle beyond GAP).
REQ-021 SHALL, on abort=1 in any non-IDLE state, enter IDLE next edge with A=B=0, counters cleared, no done.
REQ-022 SHALL ignore hold_len/rep changes after start until the next accepted start.

Reset
REQ-023 SHALL, while rst=0, force state IDLE, A=0, B=0, busy=0, done=0, err=0, all counters 0, independent of clk.
REQ-024 SHALL, on rst assertion mid-run, drop A/B to 0 immediately and require a fresh start after release.
REQ-025 SHALL leave IDLE no earlier than the first edge after rst deassertion with start=1.

Configuration
REQ-026 SHALL gate the checker with macro AB_SEQ_GEN_CHECK_EN; ports unchanged in both builds.
REQ-027 SHALL, with AB_SEQ_GEN_CHECK_EN defined, compute expected Q = (state==HOLD) and set err on any edge where busy=1 and q_in != expected Q; err stays set until rst.
REQ-028 SHALL, without AB_SEQ_GEN_CHECK_EN, tie err to 0 and ignore q_in.

Verification
REQ-029 SHALL cover: hold_len=3, rep=1, start pulse -> A/B = 10,01,11,11,11,00 over 6 cycles, then done=1 one cycle, busy low.
REQ-030 SHALL cover: hold_len=0, rep=0 -> treated as 1/1; 4-cycle burst 10,01,11,00, then done.
REQ-031 SHALL cover: hold_len=2, rep=3 -> three 5-cycle bursts (15 busy cycles), single done, start on done cycle launches next run immediately.
REQ-032 SHALL cover: abort asserted during second HOLD cycle -> IDLE next edge, A=B=0, done stays 0, busy=0.
REQ-033 SHALL cover (CHECK_EN): reference recognizer on q_in gives err=0; forcing q_in=0 during one HOLD cycle -> err=1 and stays 1 until rst.
REQ-034 SHALL cover: rst pulsed low mid-PB -> A=B=busy=err=0 immediately without clock; new start after release runs a clean burst.
